// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper.
// Drives all 16 patterns, captures y and compares under a care mask.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic [15:0] care_mask,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  mismatch_idx
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [15:0] exp_l;
  logic [15:0] care_l;
  logic        miss;
  logic [4:0]  cnt_nx;

  assign {a, b, c, d} = idx;

  assign miss   = care_l[idx] & (y ^ exp_l[idx]);
  assign cnt_nx = mismatch_cnt + {4'd0, miss};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = SETTLE;
      SETTLE: if (cnt == CNT_LAST) state_nx = SAMPLE;
      SAMPLE: state_nx = (idx == 4'hF) ? FINISH : SETTLE;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == SETTLE),
      (state == SAMPLE): busy = 1'b1;
      (state == FINISH): begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Pattern index, settle counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      cnt          <= '0;
      exp_l        <= '0;
      care_l       <= '0;
      pass         <= 1'b0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      mismatch_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            exp_l        <= expected;
            care_l       <= care_mask;
            table_out    <= '0;
            mismatch_cnt <= '0;
            mismatch_idx <= '0;
            pass         <= 1'b0;
            idx          <= '0;
            cnt          <= '0;
          end
        end
        SETTLE: cnt <= cnt + 4'd1;
        SAMPLE: begin
          table_out[idx] <= y;
          mismatch_cnt   <= cnt_nx;
          if (miss && mismatch_cnt == 5'd0)
            mismatch_idx <= idx;
          if (idx == 4'hF) begin
            pass <= (cnt_nx == 5'd0);
          end else begin
            idx <= idx + 4'd1;
            cnt <= '0;
          end
        end
        FINISH: idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper.
// Vector table, random runs vs. truth-table model, start/reset corners.
module tb_truth_table_sweeper;

  localparam int S = 2;
  localparam int RUN = 16 * (S + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] expected;
  logic [15:0] care_mask;
  logic        a, b, c, d;
  logic        y;
  logic        busy, done, pass;
  logic [15:0] table_out;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  mismatch_idx;

  logic [15:0] func_tt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [15:0] ft;
    logic [15:0] ex;
    logic [15:0] cm;
    logic [15:0] et;
    logic [4:0]  ec;
    logic [3:0]  ei;
    logic        ep;
  } vec_t;

  always #5 clk = ~clk;

  assign y = func_tt[{a, b, c, d}];

  truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .expected(expected),
    .care_mask(care_mask),
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    .y(y),
    .busy(busy),
    .done(done),
    .pass(pass),
    .table_out(table_out),
    .mismatch_cnt(mismatch_cnt),
    .mismatch_idx(mismatch_idx)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic int popcnt(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int first_set(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Expected pattern on {a,b,c,d} n cycles after the accepting edge
  function automatic logic [3:0] pat_at(input int n);
    if (n < RUN) return 4'(n / (S + 1));
    if (n == RUN) return 4'hF;
    return 4'h0;
  endfunction

  task automatic idle_clear(input string nm);
    chk({nm, ":busy"}, busy, 0);
    chk({nm, ":done"}, done, 0);
    chk({nm, ":abcd"}, {a, b, c, d}, 0);
    chk({nm, ":table"}, table_out, 0);
    chk({nm, ":cnt"}, mismatch_cnt, 0);
    chk({nm, ":midx"}, mismatch_idx, 0);
    chk({nm, ":pass"}, pass, 0);
  endtask

  // One full run; start must be accepted at the first edge.
  // Leaves time at the first IDLE cycle after FINISH.
  task automatic run_chk(input string nm, input logic [15:0] ft,
                         input logic [15:0] ex, input logic [15:0] cm,
                         input logic [15:0] et, input logic [4:0] ec,
                         input logic [3:0] ei, input logic ep,
                         input int xs1, input int xs2,
                         input bit scramble);
    int  done_n;
    int  done_k;
    bit  abcd_ok;
    func_tt   = ft;
    expected  = ex;
    care_mask = cm;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, ":busy_rise"}, busy, 1);
    abcd_ok = ({a, b, c, d} == 4'h0);
    if (scramble) begin
      expected  = 16'($urandom);
      care_mask = 16'($urandom);
    end
    done_n = -1;
    done_k = 0;
    for (int n = 1; n <= RUN + 1; n++) begin
      @(posedge clk);
      #1;
      start = (n == xs1 || n == xs2);
      if (done) begin
        done_k++;
        if (done_n < 0) done_n = n;
      end
      if ({a, b, c, d} != pat_at(n)) abcd_ok = 1'b0;
    end
    start = 1'b0;
    chk({nm, ":done_at"}, done_n, RUN);
    chk({nm, ":done_cnt"}, done_k, 1);
    chk({nm, ":abcd_seq"}, abcd_ok, 1);
    chk({nm, ":busy_end"}, busy, 0);
    chk({nm, ":table"}, table_out, et);
    chk({nm, ":cnt"}, mismatch_cnt, ec);
    if (ec != 0) chk({nm, ":midx"}, mismatch_idx, ei);
    chk({nm, ":pass"}, pass, ep);
  endtask

  vec_t vt[4];

  initial begin
    logic [15:0] rf, re, rc, mm;

    vt[0] = '{"and_ok", 16'hF000, 16'hF000, 16'hFFFF,
              16'hF000, 5'd0, 4'd0, 1'b1};
    vt[1] = '{"and_bad0", 16'hF000, 16'hF001, 16'hFFFF,
              16'hF000, 5'd1, 4'd0, 1'b0};
    vt[2] = '{"and_masked", 16'hF000, 16'hF020, 16'hFFDF,
              16'hF000, 5'd0, 4'd0, 1'b1};
    vt[3] = '{"xor4", 16'h6996, 16'h0000, 16'hFFFF,
              16'h6996, 5'd8, 4'd1, 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    expected  = 16'hFFFF;
    care_mask = 16'hFFFF;
    func_tt   = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    idle_clear("reset");
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_prio_busy", busy, 0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++)
      run_chk(vt[i].nm, vt[i].ft, vt[i].ex, vt[i].cm,
              vt[i].et, vt[i].ec, vt[i].ei, vt[i].ep,
              -1, -1, 1'b0);

    // Stray starts mid-run, then back-to-back run from first IDLE cycle
    run_chk("ignore_start", 16'hF000, 16'hF000, 16'hFFFF,
            16'hF000, 5'd0, 4'd0, 1'b1, 5, RUN - 1, 1'b0);
    run_chk("back2back", 16'hF000, 16'hF000, 16'hFFFF,
            16'hF000, 5'd0, 4'd0, 1'b1, -1, -1, 1'b0);

    // Random functions, masks and expectations vs. set-level model
    for (int r = 0; r < 20; r++) begin
      rf = 16'($urandom);
      re = (r % 4 == 0) ? rf : 16'($urandom);
      rc = (r % 3 == 0) ? 16'hFFFF : 16'($urandom);
      mm = (rf ^ re) & rc;
      run_chk($sformatf("rand%0d", r), rf, re, rc, rf,
              5'(popcnt(mm)), 4'(first_set(mm)), (mm == 16'h0),
              -1, -1, 1'b1);
    end

    // Reset in the middle of a run with nonzero partial results
    func_tt   = 16'h6996;
    expected  = 16'h0000;
    care_mask = 16'hFFFF;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_cnt", mismatch_cnt, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_clear("mid_rst");
    begin
      int dk = 0;
      for (int n = 0; n < RUN + 4; n++) begin
        @(posedge clk);
        #1;
        if (done || busy) dk++;
      end
      chk("mid_rst_quiet", dk, 0);
    end
    run_chk("after_rst", 16'h6996, 16'h0000, 16'hFFFF,
            16'h6996, 5'd8, 4'd1, 1'b0, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Synthesizable self-test engine that exhaustively sweeps all 16 combinations of a 4-input combinational block under test and drives its inputs a, b, c, d. It samples the block's single output y for each combination and assembles the captured 16-entry truth table. It compares the table against an expected table under a care mask and reports pass/fail, the mismatch count and the first failing index. It is the on-chip stimulus/response counterpart used to check small 4-input logic functions in hardware.

Parameters:
SETTLE_CYCLES, 2, cycles each input pattern is held before y is sampled; legal range 1..15

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  run request; accepted only in IDLE
expected  input  16  expected truth table; bit k = expected y for pattern k; latched on accepted start
care_mask  input  16  bit k = 1 means pattern k is compared; latched on accepted start
a  output  1  input to block under test = idx[3]
b  output  1  = idx[2]
c  output  1  = idx[1]
d  output  1  = idx[0]
y  input  1  output of block under test
busy  output  1  high in SETTLE, SAMPLE, FINISH
done  output  1  one-cycle pulse, high exactly while in FINISH
pass  output  1  1 if no cared mismatch in last run; held until next accepted start
table_out  output  16  captured truth table, bit k = sampled y for pattern k
mismatch_cnt  output  5  number of cared mismatches, 0..16
mismatch_idx  output  4  first mismatching pattern index; meaningful only when mismatch_cnt != 0

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, idx=0, settle counter=0, busy=0, done=0, pass=0, table_out=0, mismatch_cnt=0, mismatch_idx=0, latched expected/care_mask=0. Reset has priority over every other event. Reset mid-run aborts immediately: no done pulse, and all results are cleared.
- {a,b,c,d} always equals the idx register (a = MSB), so it is 0000 in IDLE.
- IDLE: start=1 at an edge causes the following updates:
  - latch expected and care_mask
  - clear table_out, mismatch_cnt, mismatch_idx and pass
  - set idx=0 and counter=0
  - go to SETTLE
- SETTLE: counter increments each cycle. The edge where counter==SETTLE_CYCLES-1 moves to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle), at its closing edge:
  - table_out[idx] <= y.
  - If care_mask_l[idx]=1 and y != expected_l[idx]: mismatch_cnt += 1. If this is the first such mismatch of the run, mismatch_idx <= idx.
  - If idx==15: go to FINISH. pass <= 1 only if the final mismatch_cnt (including this sample) is 0.
  - Otherwise: idx += 1, counter=0, go to SETTLE.
- FINISH (one cycle): done=1, busy=1, idx holds 15. At the next edge go to IDLE and set idx=0.
- Each pattern occupies SETTLE_CYCLES+1 cycles. With start accepted at edge E0, done is high in the cycle following edge E0 + 16*(SETTLE_CYCLES+1).
- start is ignored in SETTLE, SAMPLE and FINISH; there is no queuing. A start in the first IDLE cycle after FINISH is accepted normally.
- Changes on expected/care_mask during a run have no effect on that run.
- y is assumed stable by the sample edge; no synchronizer is included since the block under test is on the same clock domain.

Test Plan:
1. SETTLE_CYCLES=2, block under test y=a&b, expected=16'hF000, care_mask=16'hFFFF, start pulse -> busy rises next cycle. done pulses once 48 cycles after the start edge. table_out=16'hF000, pass=1, mismatch_cnt=0.
2. Same block, expected=16'hF001 -> table_out=16'hF000, pass=0, mismatch_cnt=1, mismatch_idx=0.
3. Same block, expected=16'hF020, care_mask=16'hFFDF -> pass=1, mismatch_cnt=0, table_out=16'hF000. Pattern 5 is still driven (a,b,c,d=0101 observed on outputs).
4. Block y=a^b^c^d, expected=16'h0000 -> table_out=16'h6996, mismatch_cnt=8, mismatch_idx=1, pass=0.
5. Additional start pulses at cycles 5 and 47 after the first start -> ignored: exactly one done, same results as scenario 1. A start in the IDLE cycle after done launches a second run with identical results.
6. rst=1 at cycle 20 of a run -> next cycle: busy=0, abcd=0000, table_out=0, mismatch_cnt=0, pass=0, and no done pulse. A following start completes normally.
